// File: rtl/decode_seq_pkg.sv
// rtl/decode_seq_pkg.sv - shared widths and state encoding for the decode sequencer
package decode_seq_pkg;

  localparam int Q_W    = 16;
  localparam int CODE_W = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/decode_seq_dec4to16.sv
// rtl/decode_seq_dec4to16.sv - combinational 4-to-16 one-hot decoder, Q[0] leftmost
module dec4to16
  import decode_seq_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [0:Q_W-1]    o_onehot
);

  // Raise only the bit selected by the code.
  always_comb begin
    o_onehot         = '0;
    o_onehot[i_code] = 1'b1;
  end

endmodule

// File: rtl/decode_seq.sv
// rtl/decode_seq.sv - one-hot drive sequencer with dwell, optional rotate and trailing gap
module decode_seq
  import decode_seq_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int GAP   = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [CODE_W-1:0] C_IN,
  input  logic              C_VALID,
  output logic              C_READY,
  input  logic              ROT,
  output logic [0:Q_W-1]    Q,
  output logic [CODE_W-1:0] C_OUT,
  output logic              BUSY,
  output logic              DONE
);

  // Counters count down to zero; the terminal value is loaded on entry.
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  state_t              r_state;
  logic [0:Q_W-1]      r_q;
  logic [CODE_W-1:0]   r_code;
  logic [CNT_W-1:0]    r_dwell_cnt;
  logic [CNT_W-1:0]    r_gap_cnt;
  logic                r_done;
  logic [0:Q_W-1]      w_onehot;

  dec4to16 u_dec (
    .i_code   (C_IN),
    .o_onehot (w_onehot)
  );

  // Sequencer: accept a code in IDLE, hold it DWELL cycles, rotate or fall into GAP.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_q         <= '0;
      r_code      <= '0;
      r_dwell_cnt <= '0;
      r_gap_cnt   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (C_VALID) begin
            r_q         <= w_onehot;
            r_code      <= C_IN;
            r_dwell_cnt <= DWELL_LAST;
            r_state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (r_dwell_cnt != '0) begin
            r_dwell_cnt <= r_dwell_cnt - 1'b1;
          end else if (ROT) begin
            // Move one position to the right; the code tracks the bit index.
            r_q         <= {r_q[Q_W-1], r_q[0:Q_W-2]};
            r_code      <= r_code + 1'b1;
            r_dwell_cnt <= DWELL_LAST;
          end else begin
            r_q <= '0;
            if (GAP > 0) begin
              r_gap_cnt <= GAP_LAST;
              r_state   <= ST_GAP;
            end else begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_q     <= '0;
        end
      endcase
    end
  end

  assign C_READY = (r_state == ST_IDLE);
  assign BUSY    = (r_state != ST_IDLE);
  assign Q       = r_q;
  assign C_OUT   = r_code;
  assign DONE    = r_done;

endmodule

// File: tb/tb_decode_seq.sv
// tb/tb_decode_seq.sv - scoreboard bench for decode_seq
module tb_decode_seq;

  localparam int DWELL_P = 2;
  localparam int GAP_P   = 1;

  logic        CLK;
  logic        RST_N;
  logic [3:0]  C_IN;
  logic        C_VALID;
  logic        C_READY;
  logic        ROT;
  logic [0:15] Q;
  logic [3:0]  C_OUT;
  logic        BUSY;
  logic        DONE;

  logic [3:0]  c_in2;
  logic        c_valid2;
  logic        c_ready2;
  logic        rot2;
  logic [0:15] q2;
  logic [3:0]  c_out2;
  logic        busy2;
  logic        done2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         busy;
    bit         done;
    int         idx;
    logic [3:0] code;
  } rec_t;

  rec_t sb[$];

  decode_seq #(.DWELL(DWELL_P), .GAP(GAP_P)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .C_IN(C_IN), .C_VALID(C_VALID), .C_READY(C_READY),
    .ROT(ROT), .Q(Q), .C_OUT(C_OUT), .BUSY(BUSY), .DONE(DONE)
  );

  decode_seq #(.DWELL(1), .GAP(0)) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .C_IN(c_in2), .C_VALID(c_valid2), .C_READY(c_ready2),
    .ROT(rot2), .Q(q2), .C_OUT(c_out2), .BUSY(busy2), .DONE(done2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [0:15] onehot_of(input int idx);
    logic [15:0] v;
    v = (idx < 0) ? 16'h0000 : (16'h8000 >> idx);
    return v;
  endfunction

  // Monitor: pop one expected record for every cycle the DUT is busy or signals done.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (BUSY || DONE) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output actual busy=%0b done=%0b required none at %0t", BUSY, DONE, $time);
        end else begin
          rec_t r;
          r = sb.pop_front();
          chk("q",     32'(Q),       32'(onehot_of(r.idx)));
          chk("busy",  32'(BUSY),    32'(r.busy));
          chk("done",  32'(DONE),    32'(r.done));
          chk("c_out", 32'(C_OUT),   32'(r.code));
          chk("ready", 32'(C_READY), 32'(!r.busy));
        end
      end
      chk("onehot", 32'($countones(Q) <= 1), 32'd1);
      if (BUSY && Q != '0) begin
        int enc;
        enc = 0;
        for (int i = 0; i < 16; i++) if (Q[i]) enc = i;
        chk("loopback_enc", 32'(C_OUT), 32'(enc));
      end
    end
  end

  // Issue one transfer of code c with r rotations; returns in the done cycle.
  task automatic run_txn(input logic [3:0] c, input int r);
    int   d;
    int   n;
    rec_t e;
    d = DWELL_P;
    n = d * (r + 1) + GAP_P + 1;
    for (int s = 0; s <= r; s++) begin
      for (int i = 0; i < d; i++) begin
        e.busy = 1'b1; e.done = 1'b0;
        e.idx  = (int'(c) + s) % 16;
        e.code = 4'(e.idx);
        sb.push_back(e);
      end
    end
    for (int g = 0; g < GAP_P; g++) begin
      e.busy = 1'b1; e.done = 1'b0; e.idx = -1;
      e.code = 4'((int'(c) + r) % 16);
      sb.push_back(e);
    end
    e.busy = 1'b0; e.done = 1'b1; e.idx = -1;
    e.code = 4'((int'(c) + r) % 16);
    sb.push_back(e);

    C_VALID = 1'b1;
    C_IN    = c;
    ROT     = 1'($urandom);
    @(posedge CLK); #1;
    for (int m = 0; m < n - 1; m++) begin
      C_VALID = 1'($urandom);
      C_IN    = 4'($urandom);
      if (m < d * (r + 1) && ((m + 1) % d) == 0) ROT = ((m + 1) / d <= r);
      else ROT = 1'($urandom);
      @(posedge CLK); #1;
    end
    C_VALID = 1'b0;
    ROT     = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; C_IN = '0; C_VALID = 1'b0; ROT = 1'b0;
    c_in2 = '0; c_valid2 = 1'b0; rot2 = 1'b0;
    #2;
    chk("rst_q",     32'(Q),        32'd0);
    chk("rst_busy",  32'(BUSY),     32'd0);
    chk("rst_done",  32'(DONE),     32'd0);
    chk("rst_c_out", 32'(C_OUT),    32'd0);
    chk("rst_ready", 32'(C_READY),  32'd1);
    chk("rst_q2",    32'(q2),       32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    run_txn(4'd5, 0);
    C_VALID = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    run_txn(4'd15, 2);
    C_VALID = 1'b0;
    @(posedge CLK); #1;
    run_txn(4'd3, 0);
    run_txn(4'd9, 0);

    // Asynchronous reset in the middle of a drive.
    C_IN = 4'd7; C_VALID = 1'b1; ROT = 1'b0;
    e_push_drive();
    @(posedge CLK); #1;
    C_VALID = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    chk("midrst_q",     32'(Q),       32'd0);
    chk("midrst_busy",  32'(BUSY),    32'd0);
    chk("midrst_done",  32'(DONE),    32'd0);
    chk("midrst_ready", 32'(C_READY), 32'd1);
    sb.delete();
    @(posedge CLK); #1;
    RST_N = 1'b1;
    run_txn(4'd12, 1);

    for (int t = 0; t < 40; t++) begin
      int idle;
      idle = $urandom_range(0, 2);
      C_VALID = 1'b0;
      for (int i = 0; i < idle; i++) begin
        C_IN = 4'($urandom);
        ROT  = 1'($urandom);
        @(posedge CLK); #1;
      end
      run_txn(4'($urandom), $urandom_range(0, 2));
    end
    C_VALID = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end

    // Minimum dwell with no gap on the second instance.
    c_in2 = 4'd0; c_valid2 = 1'b1;
    @(posedge CLK); #1;
    c_valid2 = 1'b0;
    chk("d1_q",     32'(q2),     32'h8000);
    chk("d1_busy",  32'(busy2),  32'd1);
    chk("d1_c_out", 32'(c_out2), 32'd0);
    @(posedge CLK); #1;
    chk("d1_q_clr", 32'(q2),       32'd0);
    chk("d1_done",  32'(done2),    32'd1);
    chk("d1_busy0", 32'(busy2),    32'd0);
    chk("d1_ready", 32'(c_ready2), 32'd1);
    @(posedge CLK); #1;
    chk("d1_done0", 32'(done2),    32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Expected first drive cycle of the transfer that the mid-drive reset aborts.
  task automatic e_push_drive();
    rec_t e;
    e.busy = 1'b1; e.done = 1'b0; e.idx = 7; e.code = 4'd7;
    sb.push_back(e);
  endtask

endmodule
